// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the scan-match memory read sequencer.
//   state_e      : sequencer FSM states
//   DEFAULT_DATA : data returned on a lookup timeout (all ones, truncated to DW)
//   TIMEOUT_DEF  : default WAIT-cycle budget; TCNT_W is the matching counter width
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_DATA = '1;
    localparam int unsigned TIMEOUT_DEF  = 72;
    localparam int unsigned TCNT_W       = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   CLK    in  1     clock
//   RST_N  in  1     synchronous active-low reset (pointer -> client 0)
//   REQ    in  NREQ  request vector
//   ADV    in  1     advance strobe: move priority past the client in WIN
//   WIN    in  NREQ  one-hot client that was served
//   GNT_C  out NREQ  combinational one-hot grant (zero when no request)
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ,
    input  logic            ADV,
    input  logic [NREQ-1:0] WIN,
    output logic [NREQ-1:0] GNT_C
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [NREQ-1:0]   pick_rot;
    logic [2*NREQ-1:0] pick_dbl;

    // Rotate so the pointer client sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {REQ, REQ} >> ptr_q;
        req_rot  = req_dbl[NREQ-1:0];
        pick_rot = req_rot & (~req_rot + NREQ'(1));
        pick_dbl = {pick_rot, pick_rot} << ptr_q;
        GNT_C    = pick_dbl[2*NREQ-1:NREQ];
    end

    // Next pointer: the client just after the one served.
    always_comb begin
        ptr_d = ptr_q;
        if (ADV) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                if (WIN[k]) begin
                    ptr_d = (k == int'(NREQ) - 1) ? '0 : PW'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_read_sequencer.sv
// Shares the scan-match lookup memory between NREQ clients. Each lookup restarts the
// memory counter, drives the address, waits for the active-low match strobe and returns
// the captured data (or all-ones with RSP_ERR on timeout) to the granted client.
// Ports:
//   CLK, RST_N  clock, synchronous active-low reset
//   REQ         per-client level request, held until GNT
//   REQ_ADDR    client i address at [i*AW +: AW]
//   GNT         one-hot 1-cycle accept pulse
//   RSP_VALID   one-hot 1-cycle response pulse
//   RSP_DATA    lookup result (held until next response)
//   RSP_ERR     timeout flag (held until next response)
//   BUSY        high whenever not IDLE
//   MEM_RST     active-high memory counter reset
//   MEM_ADD     address to memory
//   MEM_CLR     active-low match strobe from memory
//   MEM_DATA    memory data, valid while MEM_CLR is low
module mem_read_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 6,
    parameter int unsigned DW      = 6,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NREQ-1:0]  REQ,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    output logic [NREQ-1:0]  GNT,
    output logic [NREQ-1:0]  RSP_VALID,
    output logic [DW-1:0]    RSP_DATA,
    output logic             RSP_ERR,
    output logic             BUSY,
    output logic             MEM_RST,
    output logic [AW-1:0]    MEM_ADD,
    input  logic             MEM_CLR,
    input  logic [DW-1:0]    MEM_DATA
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [NREQ-1:0] win_q, win_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;
    logic            mem_rst_q, mem_rst_d;
    logic            arb_adv;
    logic [NREQ-1:0] arb_gnt_c;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .ADV   (arb_adv),
        .WIN   (win_q),
        .GNT_C (arb_gnt_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        arb_adv     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|REQ) begin
                    win_d   = arb_gnt_c;
                    gnt_d   = arb_gnt_c;
                    state_d = ISSUE;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (arb_gnt_c[i]) begin
                            addr_d = REQ_ADDR[i*AW +: AW];
                        end
                    end
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // First WAIT cycle carries a stale compare from the counter reset.
                if ((wcnt_q != '0) && !MEM_CLR) begin
                    rsp_data_d  = MEM_DATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = win_q;
                    state_d     = RESP;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    rsp_data_d  = DW'(DEFAULT_DATA);
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = win_q;
                    state_d     = RESP;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            RESP: begin
                arb_adv = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        mem_rst_d = (state_d != WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            win_q       <= '0;
            addr_q      <= '0;
            wcnt_q      <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mem_rst_q   <= mem_rst_d;
        end
    end

    assign GNT       = gnt_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = busy_q;
    assign MEM_RST   = mem_rst_q;
    assign MEM_ADD   = addr_q;

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Directed bench for mem_read_sequencer with a behavioural scan-match memory:
// free-running address counter cleared by MEM_RST, registered compare/data outputs.
module tb_mem_read_sequencer;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned AW      = 6;
    localparam int unsigned DW      = 6;
    localparam int unsigned TIMEOUT = 72;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              mem_rst;
    logic [AW-1:0]     mem_add;
    logic              mem_clr;
    logic [DW-1:0]     mem_data;

    // Memory model state and fault-injection knobs.
    logic [AW-1:0]     cnt = '0;
    logic              m_clr = 1'b1;
    logic [DW-1:0]     m_data = '0;
    logic              force_low = 1'b0;
    logic              stuck_high = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_read_sequencer #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req),
        .REQ_ADDR  (req_addr),
        .GNT       (gnt),
        .RSP_VALID (rsp_valid),
        .RSP_DATA  (rsp_data),
        .RSP_ERR   (rsp_err),
        .BUSY      (busy),
        .MEM_RST   (mem_rst),
        .MEM_ADD   (mem_add),
        .MEM_CLR   (mem_clr),
        .MEM_DATA  (mem_data)
    );

    always @(posedge clk) begin
        cnt    <= mem_rst ? '0 : cnt + 1'b1;
        m_clr  <= (cnt != mem_add);
        m_data <= cnt;
    end

    assign mem_clr  = force_low ? 1'b0 : (stuck_high ? 1'b1 : m_clr);
    assign mem_data = m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Call at a negedge with REQ already driven; cycle counting starts at the next edge.
    task automatic run_txn(input string tag, input int cl, input int exp_data, input int exp_err,
                           input int gnt_cyc, input int rsp_cyc, input bit drop, input int release_at);
        bit g_seen = 1'b0;
        bit r_seen = 1'b0;
        for (int k = 1; k <= 200 && !r_seen; k++) begin
            next_cycle();
            if (k == release_at) force_low = 1'b0;
            if (gnt != '0 && !g_seen) begin
                g_seen = 1'b1;
                check({tag, "_gnt_cyc"}, k, gnt_cyc);
                check({tag, "_gnt_vec"}, gnt, 1 << cl);
                if (drop) req = req & ~(NREQ'(1) << cl);
            end
            if (rsp_valid != '0) begin
                r_seen = 1'b1;
                check({tag, "_rsp_cyc"}, k, rsp_cyc);
                check({tag, "_rsp_vec"}, rsp_valid, 1 << cl);
                check({tag, "_rsp_data"}, rsp_data, exp_data);
                check({tag, "_rsp_err"}, rsp_err, exp_err);
            end
        end
        if (!r_seen) check({tag, "_rsp_seen"}, 0, 1);
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_rst", mem_rst, 1);
        check("rst_mem_add", mem_add, 0);
        rst_n = 1'b1;
        next_cycle();

        // 1: client 0, address 5
        req_addr = {6'd0, 6'd5};
        req      = 2'b01;
        run_txn("t1", 0, 5, 0, 1, 9, 1'b1, -1);
        next_cycle();

        // 2: address extremes; order leaves the pointer at client 0
        req_addr = {6'd0, 6'd0};
        req      = 2'b01;
        run_txn("t2_a0", 0, 0, 0, 1, 4, 1'b1, -1);
        next_cycle();
        req_addr = {6'd63, 6'd0};
        req      = 2'b10;
        run_txn("t2_a63", 1, 63, 0, 1, 67, 1'b1, -1);
        next_cycle();

        // 3: both clients held; alternation and back-to-back period ADDR+5
        req_addr = {6'd7, 6'd3};
        req      = 2'b11;
        check("t3_busy_pre", busy, 0);
        run_txn("t3a", 0, 3, 0, 1, 7, 1'b0, -1);
        run_txn("t3b", 1, 7, 0, 2, 12, 1'b0, -1);
        run_txn("t3c", 0, 3, 0, 2, 8, 1'b0, -1);
        run_txn("t3d", 1, 7, 0, 2, 12, 1'b0, -1);
        req = '0;
        next_cycle();

        // 4: reset pulse mid-WAIT drops the transaction
        req_addr = {6'd0, 6'd40};
        req      = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            next_cycle();
            if (k == 1) begin
                check("t4_gnt", gnt, 1);
                req = '0;
            end
        end
        check("t4_busy_mid", busy, 1);
        check("t4_mem_rst_mid", mem_rst, 0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        check("t4_busy_after", busy, 0);
        check("t4_mem_rst_after", mem_rst, 1);
        check("t4_rsp_valid_after", rsp_valid, 0);
        check("t4_mem_add_after", mem_add, 0);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            next_cycle();
            if (rsp_valid != '0) seen = 1'b1;
        end
        check("t4_no_rsp", seen, 0);
        req_addr = {6'd0, 6'd40};
        req      = 2'b01;
        run_txn("t4_fresh", 0, 40, 0, 1, 44, 1'b1, -1);
        next_cycle();

        // 5: match strobe never arrives -> timeout
        stuck_high = 1'b1;
        req_addr   = {6'd0, 6'd10};
        req        = 2'b01;
        run_txn("t5", 0, 63, 1, 1, TIMEOUT + 2, 1'b1, -1);
        stuck_high = 1'b0;
        repeat (3) next_cycle();
        check("t5_hold_data", rsp_data, 63);
        check("t5_hold_err", rsp_err, 1);
        check("t5_hold_valid", rsp_valid, 0);

        // 6: strobe forced low while idle, then through IDLE/ISSUE/first WAIT
        force_low = 1'b1;
        seen      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (rsp_valid != '0 || busy) seen = 1'b1;
        end
        check("t6_idle_quiet", seen, 0);
        check("t6_idle_mem_rst", mem_rst, 1);
        req_addr = {6'd12, 6'd0};
        req      = 2'b10;
        run_txn("t6", 1, 12, 0, 1, 16, 1'b1, 3);
        force_low = 1'b0;
        next_cycle();
        check("t6_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
